// File: rtl/ext_mem_pipe.sv
// ext_mem_pipe: behavioural external-memory model with fixed-latency pipelined
// responses, byte-addressed sub-word access, sign/zero extension and an error flag.
//
// Optional build macro: EXT_MEM_STALL_EN enables pseudo-random request
// back-pressure driven by a 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11).
//
// Parameters:
//   ADDR_W  request/response address width
//   DEPTH   number of 64-bit words in `mem` (power of 2)
//   LATENCY cycles from request accept to response valid (1..16)
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   mem_req_ready_o             request may be accepted this cycle
//   mem_req_valid_i/addr_i/cmd_i/typ_i/data_i   request channel
//   mem_resp_valid_o/addr_o/cmd_o/typ_o/data_o/err_o  response channel (no ready)
module ext_mem_pipe #(
  parameter int unsigned ADDR_W  = 40,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req_ready_o,
  input  logic              mem_req_valid_i,
  input  logic [ADDR_W-1:0] mem_req_addr_i,
  input  logic [4:0]        mem_req_cmd_i,
  input  logic [2:0]        mem_req_typ_i,
  input  logic [63:0]       mem_req_data_i,
  output logic              mem_resp_valid_o,
  output logic [ADDR_W-1:0] mem_resp_addr_o,
  output logic [4:0]        mem_resp_cmd_o,
  output logic [2:0]        mem_resp_typ_o,
  output logic [63:0]       mem_resp_data_o,
  output logic              mem_resp_err_o
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned DATA_W = 64;

  localparam logic [4:0] CMD_XWR = 5'd1;

  localparam logic [2:0] TYP_B  = 3'd0;
  localparam logic [2:0] TYP_H  = 3'd1;
  localparam logic [2:0] TYP_W  = 3'd2;
  localparam logic [2:0] TYP_BU = 3'd4;
  localparam logic [2:0] TYP_HU = 3'd5;
  localparam logic [2:0] TYP_WU = 3'd6;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [4:0]        cmd;
    logic [2:0]        typ;
    logic [63:0]       data;
    logic              err;
  } resp_t;

  // Data array; deliberately never reset so it can be preloaded hierarchically.
  logic [DATA_W-1:0] mem [DEPTH];

  resp_t pipe_q [LATENCY];

  logic stall_ok;

  // Back-pressure source.
`ifdef EXT_MEM_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall_ok = ~(lfsr_q[0] & lfsr_q[1]);
`else
  assign stall_ok = 1'b1;
`endif

  assign mem_req_ready_o = ~reset & stall_ok;

  logic              accept;
  logic              is_store;
  logic [IDX_W-1:0]  word_idx;
  logic [2:0]        byte_off;
  logic [5:0]        shift_amt;
  logic [7:0]        lane_base;
  logic [7:0]        byte_mask;
  logic [63:0]       bit_mask;
  logic [2:0]        align_mask;
  logic              out_of_range;
  logic              misaligned;
  logic              req_err;
  logic [63:0]       rd_word;
  logic [63:0]       wr_word;
  logic [63:0]       ld_shift;
  logic [63:0]       ld_ext;
  logic [63:0]       resp_data;

  // Request decode, store merge and load extraction.
  always_comb begin
    accept       = mem_req_valid_i & mem_req_ready_o;
    is_store     = (mem_req_cmd_i == CMD_XWR);
    word_idx     = mem_req_addr_i[IDX_W+2:3];
    byte_off     = mem_req_addr_i[2:0];
    shift_amt    = {byte_off, 3'b000};
    align_mask   = 3'((4'd1 << mem_req_typ_i[1:0]) - 4'd1);
    out_of_range = ((mem_req_addr_i >> (IDX_W + 3)) != '0);
    misaligned   = ((byte_off & align_mask) != 3'd0);
    req_err      = out_of_range | misaligned;

    lane_base = 8'h00;
    case (mem_req_typ_i[1:0])
      2'd0:    lane_base = 8'h01;
      2'd1:    lane_base = 8'h03;
      2'd2:    lane_base = 8'h0F;
      default: lane_base = 8'hFF;
    endcase
    // Only meaningful for aligned requests, where the shift never overflows.
    byte_mask = lane_base << byte_off;
    bit_mask  = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      bit_mask[b*8 +: 8] = {8{byte_mask[b]}};
    end

    rd_word  = mem[word_idx];
    wr_word  = (rd_word & ~bit_mask) | ((mem_req_data_i << shift_amt) & bit_mask);
    ld_shift = rd_word >> shift_amt;

    ld_ext = ld_shift;
    case (mem_req_typ_i)
      TYP_B:   ld_ext = {{56{ld_shift[7]}},  ld_shift[7:0]};
      TYP_H:   ld_ext = {{48{ld_shift[15]}}, ld_shift[15:0]};
      TYP_W:   ld_ext = {{32{ld_shift[31]}}, ld_shift[31:0]};
      TYP_BU:  ld_ext = {56'd0, ld_shift[7:0]};
      TYP_HU:  ld_ext = {48'd0, ld_shift[15:0]};
      TYP_WU:  ld_ext = {32'd0, ld_shift[31:0]};
      default: ld_ext = ld_shift;
    endcase

    resp_data = (is_store | req_err) ? 64'd0 : ld_ext;
  end

  // Store commit at the accept edge; erroneous stores are dropped.
  always_ff @(posedge clk) begin
    if (accept && is_store && !req_err) begin
      mem[word_idx] <= wr_word;
    end
  end

  // Fixed-latency response pipeline; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        pipe_q[0] <= '{valid: 1'b1, addr: mem_req_addr_i, cmd: mem_req_cmd_i,
                       typ: mem_req_typ_i, data: resp_data, err: req_err};
      end else begin
        pipe_q[0] <= '0;
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign mem_resp_valid_o = pipe_q[LATENCY-1].valid;
  assign mem_resp_addr_o  = pipe_q[LATENCY-1].addr;
  assign mem_resp_cmd_o   = pipe_q[LATENCY-1].cmd;
  assign mem_resp_typ_o   = pipe_q[LATENCY-1].typ;
  assign mem_resp_data_o  = pipe_q[LATENCY-1].data;
  assign mem_resp_err_o   = pipe_q[LATENCY-1].err;

endmodule
